ysyx_22040125_fetch_ctrl: RTL and testbench
===========================================

// Module: ysyx_22040125_fetch_ctrl
// PURPOSE
//  Instruction-fetch initiator that drives the synchronous instruction ROM. Owns the fetch PC,
//  issues one read per cycle, and absorbs the ROM's 1-cycle read latency in a 2-entry buffer.
//  Hands {pc, inst} pairs to decode over a valid/ready handshake; handles redirect and halt.
// PARAMETERS
//  RESET_PC  64'h8000_0000  first fetch address after reset
//  PC_W      64             PC width
//  INST_W    32             instruction width
// PORTS
//  clk            in   1       clock, all state updates on posedge
//  rst            in   1       synchronous reset, active-low (0 = reset)
//  mem_req        out  1       ROM read issued this cycle
//  mem_pc         out  PC_W    ROM read address (valid when mem_req=1)
//  mem_inst       in   INST_W  ROM data; valid the cycle after the matching mem_req
//  redirect_valid in   1       branch/jump/trap redirect, 1-cycle pulse
//  redirect_pc    in   PC_W    redirect target
//  halt_req       in   1       stop fetching (ebreak), 1-cycle pulse
//  out_valid      out  1       buffer head valid to decode
//  out_ready      in   1       decode accepts head
//  out_pc         out  PC_W    PC of head instruction
//  out_inst       out  INST_W  head instruction
//  fetch_count    out  64      number of accepted instructions (wraps at 2^64)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=S_START, fetch_pc=RESET_PC, inflight=0, buffer count=0;
//   out_valid=0, out_pc=0, out_inst=0, fetch_count=0; mem_req=0 while rst=0. Reset wins over all.
//  States: S_START -> S_RUN after one cycle (no issue in S_START). S_RUN -> S_HALT on halt_req.
//   S_HALT -> S_RUN on redirect_valid. redirect_valid in S_START also -> S_RUN.
//  ROM contract: ROM samples mem_pc at posedge when mem_req=1; mem_inst valid in the next cycle.
//   inflight <= mem_req each cycle; inflight_pc <= mem_pc.
//  mem_pc = redirect_valid ? redirect_pc : fetch_pc (combinational).
//  mem_req = (state==S_RUN || redirect_valid) && (redirect_valid || count+inflight<2 || pop).
//   pop = out_valid && out_ready; path out_ready->mem_req is combinational by design.
//  On issue: fetch_pc <= mem_pc + 4 (PC_W modulo, wraps silently). halt_req same cycle: issue
//   suppressed unless redirect_valid also set (redirect wins, state -> S_RUN).
//  Push: inflight && !redirect_valid -> {inflight_pc, mem_inst} written at tail.
//  Buffer: 2-entry FIFO; out_* driven from head register. push+pop same cycle: count unchanged,
//   push while full cannot occur (issue rule); pop while empty ignored.
//  Redirect: buffer cleared (count<=0), returning response discarded, redirect_pc issued the
//   same cycle, so first post-redirect instruction is visible 2 cycles after the pulse.
//  pop in a redirect cycle still counts as accepted: fetch_count increments on every pop.
//  S_HALT: no issue; in-flight response still pushed; buffer drains normally.
//  out_pc/out_inst hold their value while out_valid=1 && out_ready=0.
// TESTING
//  1 rst=0 2 cycles then 1, out_ready=1, ROM inst=pc[31:0] -> mem_req first at cycle 2,
//    out_pc 0x80000000,0x80000004,0x80000008 on consecutive cycles, fetch_count=3.
//  2 out_ready=0 for 5 cycles mid-stream -> mem_req drops once count+inflight=2, out_pc stable,
//    after release PCs continue +4 with no gap/duplicate.
//  3 buffer full, redirect_valid pc=0x80000100 -> mem_pc=0x80000100 same cycle, out_valid=0 next
//    cycle, out_pc=0x80000100 cycle after, then 0x80000104.
//  4 redirect_valid and pop same cycle -> fetch_count +1, popped entry not re-presented,
//    stale ROM response dropped.
//  5 halt_req at pc 0x80000010 -> no mem_req from that cycle, buffered entries drain, out_valid=0;
//    redirect to 0x80000000 -> fetch resumes.
//  6 rst=0 with full buffer and inflight -> next cycle out_valid=0, fetch_count=0, restart at RESET_PC.

Source files
------------

// File: rtl/ysyx_22040125_fetch_ctrl.sv
// Instruction-fetch initiator: owns the fetch PC, drives the synchronous ROM,
// and buffers {pc, inst} pairs in a 2-entry FIFO for decode.
module ysyx_22040125_fetch_ctrl #(
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_pc,
    input  logic [INST_W-1:0] mem_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [63:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_START,
        S_RUN,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [1:0]      count;
    entry_t          head;
    entry_t          tail;
    entry_t          incoming;
    logic            pop;
    logic            push;
    logic            room;
    logic            issue;

    assign out_valid = (count != 2'd0);
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign pop       = out_valid && out_ready;
    assign push      = inflight && !redirect_valid;
    assign mem_pc    = redirect_valid ? redirect_pc : fetch_pc;
    assign room      = ({1'b0, count} + {2'b0, inflight}) < 3'd2;
    assign incoming  = '{pc: inflight_pc, inst: mem_inst};
    assign mem_req   = issue;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        // Redirect always issues and overrides a same-cycle halt.
        if (rst) begin
            if (redirect_valid) begin
                issue = 1'b1;
            end else if (state == S_RUN && !halt_req) begin
                issue = room || pop;
            end
        end
        if (redirect_valid) begin
            state_nx = S_RUN;
        end else begin
            unique case (state)
                S_START: state_nx = S_RUN;
                S_RUN:   state_nx = halt_req ? S_HALT : S_RUN;
                S_HALT:  state_nx = S_HALT;
                default: state_nx = S_START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_START;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            head        <= '0;
            tail        <= '0;
            fetch_count <= 64'd0;
        end else begin
            state       <= state_nx;
            inflight    <= issue;
            inflight_pc <= mem_pc;
            if (issue) fetch_pc <= mem_pc + PC_W'(4);
            if (pop) fetch_count <= fetch_count + 64'd1;
            if (redirect_valid) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) head <= incoming;
                        else tail <= incoming;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head  <= tail;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            head <= incoming;
                        end else begin
                            head <= tail;
                            tail <= incoming;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_fetch_ctrl.sv
// Scoreboard bench for ysyx_22040125_fetch_ctrl: directed stimulus queues
// expected PCs, a negedge monitor checks every accepted instruction.
module tb_ysyx_22040125_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [63:0] mem_pc;
    logic [31:0] mem_inst = 32'h0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] fetch_count;

    int          tests = 0;
    int          fails = 0;
    int          n_acc = 0;
    logic [63:0] exp_q[$];

    ysyx_22040125_fetch_ctrl dut (
        .clk(clk),
        .rst(rst),
        .mem_req(mem_req),
        .mem_pc(mem_pc),
        .mem_inst(mem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // ROM returns the low word of the address one cycle after the request
    always @(posedge clk) begin
        if (mem_req) mem_inst <= mem_pc[31:0];
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst === 1'b1 && out_valid && out_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got %h want none", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", out_pc, e);
                chk("pop_inst", {32'h0, out_inst}, {32'h0, e[31:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst            = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        halt_req       = 1'b0;

        // reset, then first fetches
        tick();
        #1 chk("rst_req", {63'h0, mem_req}, 64'h0);
        tick();
        #1 chk("rst_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_fcount", fetch_count, 64'h0);
        chk("rst_outpc", out_pc, 64'h0);
        rst = 1'b1;
        push_seq(RST_PC, 4);
        #1 chk("start_noreq", {63'h0, mem_req}, 64'h0);
        tick();
        #1 chk("first_req", {63'h0, mem_req}, 64'h1);
        chk("first_pc", mem_pc, RST_PC);

        // halt when the fetch reaches RST_PC+0x10
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_pc == RST_PC + 64'h10) found = 1'b1;
            else tick();
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL halt_wait: got timeout want pc %h", RST_PC + 64'h10);
        end
        halt_req = 1'b1;
        #1 chk("halt_noreq", {63'h0, mem_req}, 64'h0);
        tick();
        halt_req = 1'b0;
        repeat (4) tick();
        chk("halted_noreq", {63'h0, mem_req}, 64'h0);
        chk("halted_valid", {63'h0, out_valid}, 64'h0);
        chk("halted_fcount", fetch_count, 64'd4);
        chk("halted_drained", 64'(exp_q.size()), 64'h0);

        // resume from halt, then stall decode for 5 cycles
        redirect_pc    = RST_PC;
        redirect_valid = 1'b1;
        push_seq(RST_PC, 40);
        #1 chk("resume_req", {63'h0, mem_req}, 64'h1);
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_valid", {63'h0, out_valid}, 64'h1);
            chk("hold_pc", out_pc, exp_q[0]);
            if (i >= 1) chk("hold_noreq", {63'h0, mem_req}, 64'h0);
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();

        // fill the buffer, then redirect while full
        out_ready = 1'b0;
        repeat (4) tick();
        redirect_pc    = 64'h8000_0100;
        redirect_valid = 1'b1;
        #1 chk("full_valid", {63'h0, out_valid}, 64'h1);
        chk("redir_req", {63'h0, mem_req}, 64'h1);
        chk("redir_mempc", mem_pc, 64'h8000_0100);
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(64'h8000_0100, 30);
        #1 chk("flush_valid", {63'h0, out_valid}, 64'h0);
        tick();
        #1 chk("post_valid", {63'h0, out_valid}, 64'h1);
        chk("post_pc", out_pc, 64'h8000_0100);
        out_ready = 1'b1;
        repeat (5) tick();

        // redirect coinciding with a pop
        redirect_pc    = 64'h8000_0200;
        redirect_valid = 1'b1;
        #1 chk("rp_valid", {63'h0, out_valid}, 64'h1);
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        push_seq(64'h8000_0200, 30);
        #1 chk("rp_flush", {63'h0, out_valid}, 64'h0);
        chk("rp_fcount", fetch_count, 64'(n_acc));
        tick();
        #1 chk("rp_pc", out_pc, 64'h8000_0200);
        repeat (5) tick();

        // reset with a full buffer
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1 chk("rst2_noreq", {63'h0, mem_req}, 64'h0);
        tick();
        #1 chk("rst2_valid", {63'h0, out_valid}, 64'h0);
        chk("rst2_fcount", fetch_count, 64'h0);
        chk("rst2_outpc", out_pc, 64'h0);
        rst = 1'b1;
        exp_q.delete();
        push_seq(RST_PC, 30);
        n_acc     = 0;
        out_ready = 1'b1;
        tick();
        #1 chk("restart_req", {63'h0, mem_req}, 64'h1);
        chk("restart_pc", mem_pc, RST_PC);
        repeat (8) tick();
        chk("final_fcount", fetch_count, 64'(n_acc));
        chk("final_progress", {63'h0, n_acc >= 5}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
